// File: rtl/branch_resolver_pkg.sv
// Core constants shared by the branch resolution logic: BRANCH opcode,
// conditional-branch funct3 encodings and pattern-history-table defaults.
package branch_resolver_pkg;

  localparam int unsigned PHT_BITS_DEF = 5;
  localparam logic [6:0]  OP_BRANCH    = 7'b1100011;
  localparam logic [1:0]  CTR_RESET    = 2'b01;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_funct3_e;

endpackage

// File: rtl/branch_pht.sv
// Pattern history table: 2-bit saturating counters, one combinational read
// port and one synchronous update port.
module branch_pht
  import branch_resolver_pkg::*;
#(
  parameter int unsigned IDX_BITS = PHT_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [1:0]          rd_ctr,
  input  logic                upd_en,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic                upd_taken
);

  localparam int unsigned N = 1 << IDX_BITS;

  logic [1:0] ctr [N];

  // Read sees the pre-update value when the update hits the same entry.
  assign rd_ctr = ctr[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) ctr[i] <= CTR_RESET;
    end else if (upd_en) begin
      if (upd_taken && ctr[upd_idx] != '1)
        ctr[upd_idx] <= ctr[upd_idx] + 2'd1;
      else if (!upd_taken && ctr[upd_idx] != '0)
        ctr[upd_idx] <= ctr[upd_idx] - 2'd1;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves conditional branches in execute: trains the PHT, counts branches
// and mispredictions, and raises a one-cycle redirect with the corrected PC.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int unsigned PHT_BITS = PHT_BITS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic [31:0] ex_inst,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic        br_eq,
  input  logic        br_lt,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  logic [2:0] funct3;
  logic       f3_legal;
  logic       actual_taken;
  logic       resolve;
  logic       mispredict;
  logic [1:0] rd_ctr;
  logic       unused_bits;

  assign funct3 = ex_inst[14:12];

  always_comb begin
    f3_legal     = 1'b1;
    actual_taken = 1'b0;
    case (funct3)
      F3_BEQ:           actual_taken = br_eq;
      F3_BNE:           actual_taken = !br_eq;
      F3_BLT, F3_BLTU:  actual_taken = br_lt;
      F3_BGE, F3_BGEU:  actual_taken = !br_lt;
      default:          f3_legal     = 1'b0;
    endcase
  end

  // The cycle after a redirect carries wrong-path instructions, so it never resolves.
  assign resolve    = ex_valid && !ex_stall && !redirect &&
                      (ex_inst[6:0] == OP_BRANCH) && f3_legal;
  assign mispredict = resolve && (actual_taken != ex_pred_taken);

  branch_pht #(.IDX_BITS(PHT_BITS)) u_pht (
    .clk       (clk),
    .rst_n     (rst),
    .rd_idx    (if_pc[PHT_BITS+1:2]),
    .rd_ctr    (rd_ctr),
    .upd_en    (resolve),
    .upd_idx   (ex_pc[PHT_BITS+1:2]),
    .upd_taken (actual_taken)
  );

  assign pred_taken = rd_ctr[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect         <= 1'b0;
      redirect_pc      <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      redirect <= mispredict;
      if (mispredict) begin
        redirect_pc      <= actual_taken ? ex_target : ex_pc + 32'd4;
        mispredict_count <= mispredict_count + 32'd1;
      end
      if (resolve) branch_count <= branch_count + 32'd1;
    end
  end

  assign unused_bits = ^{if_pc[31:PHT_BITS+2], if_pc[1:0], ex_inst[31:15], ex_inst[11:7]};

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter PHT_BITS, default 5: log2 of the pattern-history-table entry count (32 entries).
REQ-002 Ports SHALL be:
  clk  input  1  sole clock, rising edge
  rst  input  1  asynchronous active-low reset
  if_pc  input  32  fetch-stage PC for direction lookup
  pred_taken  output  1  predicted direction for if_pc
  ex_valid  input  1  execute-stage instruction valid
  ex_stall  input  1  execute stage held this cycle
  ex_inst  input  32  execute-stage instruction
  ex_pc  input  32  execute-stage PC
  ex_target  input  32  computed branch target (ex_pc + B-immediate)
  ex_pred_taken  input  1  prediction carried down the pipe with ex_inst
  br_eq  input  1  comparator equal result
  br_lt  input  1  comparator less-than result (signedness already applied)
  redirect  output  1  registered one-cycle mispredict pulse
  redirect_pc  output  32  corrected fetch PC, valid while redirect=1
  branch_count  output  32  resolved conditional branches
  mispredict_count  output  32  resolved mispredictions

Function
REQ-003 pred_taken SHALL be combinational: bit[1] of the PHT entry indexed by if_pc[PHT_BITS+1:2].
REQ-004 A resolution event SHALL occur when ex_valid=1, ex_stall=0, redirect=0, ex_inst[6:0]=1100011, and funct3 (ex_inst[14:12]) is legal.
REQ-005 Actual direction SHALL be: 000 br_eq; 001 !br_eq; 100 and 110 br_lt; 101 and 111 !br_lt.
REQ-006 funct3 010/011 SHALL be treated as non-branch: no PHT update, no counter change, no redirect.
REQ-007 On a resolution event, the PHT entry indexed by ex_pc[PHT_BITS+1:2] SHALL update at the next edge: +1 if taken, -1 if not, saturating at 00 and 11.
REQ-008 On a resolution event, branch_count SHALL increment by 1 at the next edge.
REQ-009 Misprediction (actual != ex_pred_taken) SHALL, at the next edge, set redirect=1, increment mispredict_count, and set redirect_pc=ex_target if actually taken, else ex_pc+4 (mod 2^32).
REQ-010 redirect SHALL be high for exactly one cycle per misprediction; with no misprediction it SHALL be 0 and redirect_pc SHALL hold its last value.
REQ-011 While redirect=1, execute inputs are wrong-path and SHALL cause no resolution event.
REQ-012 While ex_stall=1, all state SHALL hold except redirect, which still clears after its one cycle.
REQ-013 If if_pc and ex_pc index the same entry in the same cycle, pred_taken SHALL return the pre-update value (read-before-write).
REQ-014 Both 32-bit counters SHALL wrap modulo 2^32.

Reset
REQ-015 While rst=0: every PHT entry = 01 (weakly not-taken), redirect=0, redirect_pc=0, branch_count=0, mispredict_count=0.
REQ-016 Reset asserted mid-operation SHALL abort any pending redirect, with no partial PHT or counter update on that edge.

Structure
REQ-017 The BRANCH opcode (1100011), the six funct3 codes, the PHT_BITS default and the counter reset value (01) SHALL live in the shared core constants package.
REQ-018 The PHT SHALL be one sub-module, branch_pht: array of 2-bit saturating counters with one combinational read port, one synchronous update port, and async active-low reset.
REQ-019 Direction decode and redirect/counter logic SHALL stay in branch_resolver; the target adder stays outside the block.

Verification
REQ-020 Reset then if_pc=0x100 -> pred_taken=0; all outputs 0.
REQ-021 BEQ at ex_pc=0x100, br_eq=1, ex_pred_taken=0, ex_target=0x140 -> next cycle redirect=1, redirect_pc=0x140, mispredict_count=1, branch_count=1; entry 0 = 10; following cycle redirect=0.
REQ-022 BGEU at ex_pc=0x200, br_lt=0, taken four times, ex_pred_taken matching current pred_taken -> entry saturates at 11; exactly one redirect (first resolution), then none.
REQ-023 BNE at ex_pc=0x300, br_eq=1, ex_pred_taken=1 -> redirect_pc=0x304; same-cycle if_pc=0x300 reads the old value.
REQ-024 funct3=010 with opcode 1100011, and any valid instruction presented in the cycle redirect=1 -> no counter, PHT or redirect change.
REQ-025 Misprediction presented with rst pulsed low before the edge, and ex_stall=1 on a mispredicted branch -> no redirect and no count increment in either case.
